// File: rtl/test_status_reporter.sv
// rtl/test_status_reporter.sv - tohost CSR end-of-test reporter with verdict FSM, cycle counter and checkpoint FIFO (watchdog under TOHOST_TIMEOUT_EN)
module test_status_reporter #(
    parameter logic [11:0] CSR_ADDR       = 12'h51E,
    parameter int          CP_DEPTH       = 4,
    parameter int          TIMEOUT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [31:0] cycles,
    output logic        cp_valid,
    input  logic        cp_ready,
    output logic [31:0] cp_data,
    output logic [31:0] cp_cycle,
    output logic        cp_overflow
);

    localparam int PTR_W = $clog2(CP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    state_t state;

    logic [31:0] mem_data  [CP_DEPTH];
    logic [31:0] mem_cycle [CP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;

    logic in_run;
    logic hit;
    logic wr_pass;
    logic wr_fail;
    logic wr_cp;
    logic full;
    logic do_pop;
    logic do_push;

    // Decode of the tohost write; every action only applies while the test is still running.
    assign in_run  = (state == ST_RUN);
    assign hit     = csr_we && (csr_addr == CSR_ADDR) && in_run;
    assign wr_pass = hit && (csr_wdata == 32'd1);
    assign wr_fail = hit && csr_wdata[0] && (csr_wdata != 32'd1);
    assign wr_cp   = hit && !csr_wdata[0] && (csr_wdata != 32'd0);

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign cp_valid        = (count != '0);
    assign full            = (count == CNT_W'(CP_DEPTH));
    assign do_pop          = cp_valid && cp_ready;
    assign do_push         = wr_cp && (!full || do_pop);
    assign count_after_pop = count - CNT_W'(do_pop);
    assign rd_ptr_nxt      = rd_ptr + PTR_W'(do_pop);

`ifdef TOHOST_TIMEOUT_EN
    logic timeout_q;
    logic expire;

    // Watchdog fires on the edge where cycles steps onto the limit.
    assign expire  = in_run && (cycles == 32'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Verdict FSM; a verdict write takes priority over the watchdog in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
`ifdef TOHOST_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else if (in_run) begin
            if (wr_pass) begin
                state <= ST_PASS;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (wr_fail) begin
                state     <= ST_FAIL;
                done      <= 1'b1;
                fail_code <= csr_wdata[31:1];
            end
`ifdef TOHOST_TIMEOUT_EN
            else if (expire) begin
                state     <= ST_TIMEOUT;
                done      <= 1'b1;
                timeout_q <= 1'b1;
            end
`endif
        end
    end

    // Run-time counter: counts while running, saturates, freezes once a verdict is latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= '0;
        end else if (in_run && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end

    // Checkpoint storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr]  <= csr_wdata;
            mem_cycle[wr_ptr] <= cycles;
        end
    end

    // FIFO pointers, occupancy, overflow flag and the registered head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cp_overflow <= 1'b0;
            cp_data     <= '0;
            cp_cycle    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_after_pop + CNT_W'(do_push);
            if (wr_cp && full && !do_pop) begin
                cp_overflow <= 1'b1;
            end
            // The new entry becomes head directly when nothing older remains behind it.
            if (do_push && (count_after_pop == '0)) begin
                cp_data  <= csr_wdata;
                cp_cycle <= cycles;
            end else if (do_pop && (count_after_pop != '0)) begin
                cp_data  <= mem_data[rd_ptr_nxt];
                cp_cycle <= mem_cycle[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: tb/tb_test_status_reporter.sv
// tb/tb_test_status_reporter.sv - self-checking bench for test_status_reporter
module tb_test_status_reporter;

    localparam logic [11:0] A     = 12'h51E;
    localparam int          DEPTH = 4;
    localparam int          TOUT  = 100;
`ifdef TOHOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        cp_ready = 1'b0;
    logic        done, pass, timeout, cp_valid, cp_overflow;
    logic [30:0] fail_code;
    logic [31:0] cycles, cp_data, cp_cycle;

    int checks = 0;
    int errors = 0;

    test_status_reporter #(.CSR_ADDR(A), .CP_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout), .cycles(cycles),
        .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_data(cp_data), .cp_cycle(cp_cycle),
        .cp_overflow(cp_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: verdict flags, a run counter and a queue of checkpoints.
    bit          m_done, m_pass, m_to, m_ovf;
    logic [30:0] m_fc;
    logic [31:0] m_cyc, m_hd, m_hc;
    logic [31:0] q_data[$];
    logic [31:0] q_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit we, input logic [11:0] a, input logic [31:0] d, input bit rdy);
        bit running, hit, pop;
        logic [31:0] new_cyc;
        if (r) begin
            m_done = 0; m_pass = 0; m_to = 0; m_ovf = 0; m_fc = '0; m_cyc = '0;
            m_hd = '0; m_hc = '0;
            q_data.delete(); q_cyc.delete();
            return;
        end
        running = !m_done;
        hit     = we && (a == A) && running;
        pop     = rdy && (q_data.size() > 0);
        new_cyc = (running && m_cyc != 32'hFFFF_FFFF) ? m_cyc + 1 : m_cyc;
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_cyc.pop_front());
        end
        if (hit && d == 1) begin
            m_done = 1; m_pass = 1;
        end else if (hit && d[0]) begin
            m_done = 1; m_fc = d[31:1];
        end else if (TO_EN && running && new_cyc == TOUT) begin
            m_done = 1; m_to = 1;
        end
        if (hit && !d[0] && d != 0) begin
            if (q_data.size() < DEPTH) begin
                q_data.push_back(d);
                q_cyc.push_back(m_cyc);
            end else begin
                m_ovf = 1;
            end
        end
        m_cyc = new_cyc;
        if (q_data.size() > 0) begin
            m_hd = q_data[0];
            m_hc = q_cyc[0];
        end
    endtask

    task automatic step(input bit r, input bit we, input logic [11:0] a, input logic [31:0] d, input bit rdy);
        rst = r; csr_we = we; csr_addr = a; csr_wdata = d; cp_ready = rdy;
        @(posedge clk);
        #1;
        model(r, we, a, d, rdy);
        chk("m.done", done, m_done);
        chk("m.pass", pass, m_pass);
        chk("m.fail_code", fail_code, m_fc);
        chk("m.timeout", timeout, m_to);
        chk("m.cycles", cycles, m_cyc);
        chk("m.cp_valid", cp_valid, q_data.size() > 0);
        chk("m.cp_overflow", cp_overflow, m_ovf);
        chk("m.cp_data", cp_data, m_hd);
        chk("m.cp_cycle", cp_cycle, m_hc);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, A, 0, rdy);
    endtask

    typedef struct {
        bit          r, we;
        logic [11:0] a;
        logic [31:0] d;
        bit          rdy, e_done, e_pass;
        logic [30:0] e_fc;
        logic [31:0] e_cyc;
        bit          e_cpv;
        logic [31:0] e_cpd, e_cpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit we, logic [11:0] a, logic [31:0] d, bit rdy, bit e_done, bit e_pass,
                                logic [30:0] e_fc, logic [31:0] e_cyc, bit e_cpv, logic [31:0] e_cpd, logic [31:0] e_cpc);
        vec_t v;
        v.r = r; v.we = we; v.a = a; v.d = d; v.rdy = rdy; v.e_done = e_done; v.e_pass = e_pass;
        v.e_fc = e_fc; v.e_cyc = e_cyc; v.e_cpv = e_cpv; v.e_cpd = e_cpd; v.e_cpc = e_cpc;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_drain[$];
        logic [31:0] d;

        vecs.push_back(mk(1, 0, A, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, A, 0, 0, 0, 0, 0, i, 0, 0, 0));
        vecs.push_back(mk(0, 1, A, 2, 0, 0, 0, 0, 6, 1, 2, 5));
        for (int i = 7; i <= 9; i++) vecs.push_back(mk(0, 0, A, 0, 0, 0, 0, 0, i, 1, 2, 5));
        vecs.push_back(mk(0, 1, A, 1, 0, 1, 1, 0, 10, 1, 2, 5));
        vecs.push_back(mk(0, 0, A, 0, 0, 1, 1, 0, 10, 1, 2, 5));
        vecs.push_back(mk(0, 1, A, 4, 0, 1, 1, 0, 10, 1, 2, 5));
        vecs.push_back(mk(0, 0, A, 0, 1, 1, 1, 0, 10, 0, 2, 5));
        vecs.push_back(mk(1, 0, A, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, A, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 12'h51F, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, A, 7, 0, 1, 0, 3, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, A, 1, 0, 1, 0, 3, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, A, 8, 0, 1, 0, 3, 3, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].rdy);
            chk($sformatf("vec%0d.done", i), done, vecs[i].e_done);
            chk($sformatf("vec%0d.pass", i), pass, vecs[i].e_pass);
            chk($sformatf("vec%0d.fail_code", i), fail_code, vecs[i].e_fc);
            chk($sformatf("vec%0d.cycles", i), cycles, vecs[i].e_cyc);
            chk($sformatf("vec%0d.cp_valid", i), cp_valid, vecs[i].e_cpv);
            chk($sformatf("vec%0d.cp_data", i), cp_data, vecs[i].e_cpd);
            chk($sformatf("vec%0d.cp_cycle", i), cp_cycle, vecs[i].e_cpc);
            chk($sformatf("vec%0d.timeout", i), timeout, 0);
            chk($sformatf("vec%0d.cp_overflow", i), cp_overflow, 0);
        end

        // Overflow: fifth checkpoint is dropped, drain returns the first four.
        step(1, 0, A, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, A, 2 * i, 0);
        chk("ovf.flag", cp_overflow, 1);
        exp_drain = '{32'd2, 32'd4, 32'd6, 32'd8};
        foreach (exp_drain[i]) begin
            chk("ovf.valid", cp_valid, 1);
            chk("ovf.drain", cp_data, exp_drain[i]);
            step(0, 0, A, 0, 1);
        end
        chk("ovf.empty", cp_valid, 0);

        // Push into a full FIFO while the head pops: accepted, no overflow.
        step(1, 0, A, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, A, 2 * i, 0);
        step(0, 1, A, 12, 1);
        chk("full_pop.ovf", cp_overflow, 0);
        exp_drain = '{32'd4, 32'd6, 32'd8, 32'd12};
        foreach (exp_drain[i]) begin
            chk("full_pop.drain", cp_data, exp_drain[i]);
            step(0, 0, A, 0, 1);
        end
        chk("full_pop.empty", cp_valid, 0);

        // Reset mid-run discards queued checkpoints; then a normal pass.
        step(1, 0, A, 0, 0);
        idle(3, 0);
        step(0, 1, A, 2, 0);
        step(0, 1, A, 4, 0);
        step(1, 0, A, 0, 0);
        chk("rst.cp_valid", cp_valid, 0);
        chk("rst.cycles", cycles, 0);
        chk("rst.cp_data", cp_data, 0);
        step(0, 1, A, 1, 0);
        chk("rst.pass", pass, 1);
        chk("rst.done", done, 1);

        // Watchdog behaviour (or its absence).
        step(1, 0, A, 0, 0);
        idle(TOUT - 1, 0);
        chk("wd.before", done, 0);
        step(0, 0, A, 0, 0);
        chk("wd.done", done, TO_EN);
        chk("wd.timeout", timeout, TO_EN);
        chk("wd.pass", pass, 0);
        chk("wd.cycles", cycles, TOUT);
        idle(50, 0);
        chk("wd.frozen", cycles, TO_EN ? TOUT : TOUT + 50);
        step(1, 0, A, 0, 0);
        idle(TOUT - 1, 0);
        step(0, 1, A, 1, 0);
        chk("wd_race.pass", pass, 1);
        chk("wd_race.timeout", timeout, 0);
        chk("wd_race.cycles", cycles, TOUT);

        // Randomized traffic against the model.
        step(1, 0, A, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 39))
                0:       d = 32'd1;
                1:       d = $urandom() | 32'd1;
                2, 3:    d = 32'd0;
                default: begin
                    d = $urandom() & ~32'd1;
                    if (d == 0) d = 32'd2;
                end
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 4) == 0) ? 12'($urandom()) : A, d, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
